// File: rtl/axi4_mgr_sched.sv
// axi4_mgr_sched: round-robin scheduler sharing one axi4_mgr between NUM_REQ requesters.
// Optional watchdog with response drain is enabled by AXI4_MGR_SCHED_TIMEOUT_EN.
module axi4_mgr_sched #(
  parameter int NUM_REQ          = 4,
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 64,
  parameter int DATA_COUNT_WIDTH = 8,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  input  logic [NUM_REQ-1:0]                   req_we_i,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]    req_wdata_i,
  input  logic [NUM_REQ*DATA_COUNT_WIDTH-1:0]  req_count_i,
  output logic [NUM_REQ-1:0]                   done_o,
  output logic [1:0]                           err_o,
  output logic [AXI_DATA_WIDTH-1:0]            rdata_o,
  output logic                                 busy_o,
  output logic [$clog2(NUM_REQ)-1:0]           grant_id_o,
  output logic [1:0]                           mgr_req_o,
  output logic [AXI_ADDR_WIDTH-1:0]            mgr_wr_addr_o,
  output logic [AXI_ADDR_WIDTH-1:0]            mgr_rd_addr_o,
  output logic [AXI_DATA_WIDTH-1:0]            mgr_data_o,
  output logic [DATA_COUNT_WIDTH-1:0]          mgr_wr_count_o,
  output logic [DATA_COUNT_WIDTH-1:0]          mgr_rd_count_o,
  input  logic [1:0]                           mgr_rsp_i,
  input  logic [1:0]                           mgr_wr_err_i,
  input  logic [1:0]                           mgr_rd_err_i,
  input  logic [AXI_DATA_WIDTH-1:0]            mgr_data_i
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = AXI_ADDR_WIDTH;
  localparam int DW = AXI_DATA_WIDTH;
  localparam int CW = DATA_COUNT_WIDTH;
`ifdef AXI4_MGR_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_t;
  logic [TW-1:0] tmo_q;
`else
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
`endif
  state_t state_q;
  logic [IW-1:0] ptr_q, gnt_d, nxt_d;
  logic we_q, rsp_hit;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [CW-1:0] count_q;
  logic [NUM_REQ-1:0] ready_q, done_q;
  logic [1:0] err_q, mgr_req_q;
  logic [DW-1:0] rdata_q, mgr_data_q;
  logic busy_q;
  logic [IW-1:0] grant_q;
  logic [AW-1:0] wr_addr_q, rd_addr_q;
  logic [CW-1:0] wr_count_q, rd_count_q;
  // Scan downwards so the lowest offset from the pointer wins.
  always_comb begin
    int j;
    j = 0;
    gnt_d = ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr_q) + k) % NUM_REQ;
      if (req_valid_i[IW'(j)]) gnt_d = IW'(j);
    end
  end
  assign rsp_hit = we_q ? mgr_rsp_i[0] : mgr_rsp_i[1];
  assign nxt_d   = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      count_q    <= '0;
      ready_q    <= '0;
      done_q     <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      grant_q    <= '0;
      mgr_req_q  <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      mgr_data_q <= '0;
      wr_count_q <= '0;
      rd_count_q <= '0;
`ifdef AXI4_MGR_SCHED_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      ready_q <= '0;
      done_q  <= '0;
      case (state_q)
        IDLE: if (|req_valid_i) begin
          ready_q <= NUM_REQ'(1) << gnt_d;
          we_q    <= req_we_i[gnt_d];
          addr_q  <= req_addr_i[gnt_d*AW +: AW];
          wdata_q <= req_wdata_i[gnt_d*DW +: DW];
          count_q <= req_count_i[gnt_d*CW +: CW];
          grant_q <= gnt_d;
          busy_q  <= 1'b1;
          state_q <= REQ;
`ifdef AXI4_MGR_SCHED_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        REQ: begin
`ifdef AXI4_MGR_SCHED_TIMEOUT_EN
          tmo_q <= tmo_q + 1'b1;
`endif
          // First REQ cycle launches the command; the manager can only answer afterwards.
          if (mgr_req_q == 2'b00) begin
            mgr_req_q  <= we_q ? 2'b01 : 2'b10;
            wr_addr_q  <= we_q ? addr_q : '0;
            rd_addr_q  <= we_q ? '0 : addr_q;
            mgr_data_q <= we_q ? wdata_q : '0;
            wr_count_q <= we_q ? count_q : '0;
            rd_count_q <= we_q ? '0 : count_q;
          end else if (rsp_hit) begin
            err_q     <= we_q ? mgr_wr_err_i : mgr_rd_err_i;
            rdata_q   <= we_q ? rdata_q : mgr_data_i;
            mgr_req_q <= '0;
            done_q    <= NUM_REQ'(1) << grant_q;
            state_q   <= DONE;
`ifdef AXI4_MGR_SCHED_TIMEOUT_EN
          end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            err_q     <= 2'b11;
            rdata_q   <= '0;
            mgr_req_q <= '0;
            done_q    <= NUM_REQ'(1) << grant_q;
            state_q   <= DRAIN;
`endif
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          ptr_q   <= nxt_d;
          state_q <= IDLE;
        end
`ifdef AXI4_MGR_SCHED_TIMEOUT_EN
        DRAIN: if (rsp_hit) begin
          busy_q  <= 1'b0;
          ptr_q   <= nxt_d;
          state_q <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_ready_o    = ready_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign rdata_o        = rdata_q;
  assign busy_o         = busy_q;
  assign grant_id_o     = grant_q;
  assign mgr_req_o      = mgr_req_q;
  assign mgr_wr_addr_o  = wr_addr_q;
  assign mgr_rd_addr_o  = rd_addr_q;
  assign mgr_data_o     = mgr_data_q;
  assign mgr_wr_count_o = wr_count_q;
  assign mgr_rd_count_o = rd_count_q;
endmodule

// File: tb/tb_axi4_mgr_sched.sv
// tb_axi4_mgr_sched: table vectors, hand-written corner sequences and randomized traffic
// checked against a round-robin reference model of axi4_mgr_sched.
module tb_axi4_mgr_sched;
  logic clk, rst;
  logic [3:0] vld, we;
  logic [31:0] v_addr [4];
  logic [63:0] v_wdata [4];
  logic [7:0] v_cnt [4];
  logic [127:0] req_addr;
  logic [255:0] req_wdata;
  logic [31:0] req_count;
  logic [3:0] req_ready_o, done_o;
  logic [1:0] err_o, grant_id_o, mgr_req_o, mgr_rsp, wr_err, rd_err;
  logic [63:0] rdata_o, mgr_data_o, mgr_rdata;
  logic busy_o;
  logic [31:0] mgr_wr_addr_o, mgr_rd_addr_o;
  logic [7:0] mgr_wr_count_o, mgr_rd_count_o;
  int n_cmp = 0, n_err = 0;
  int ptr = 0;
  logic [63:0] mrd = '0;

  axi4_mgr_sched #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(vld), .req_ready_o(req_ready_o), .req_we_i(we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_count_i(req_count),
    .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .busy_o(busy_o), .grant_id_o(grant_id_o),
    .mgr_req_o(mgr_req_o), .mgr_wr_addr_o(mgr_wr_addr_o), .mgr_rd_addr_o(mgr_rd_addr_o),
    .mgr_data_o(mgr_data_o), .mgr_wr_count_o(mgr_wr_count_o), .mgr_rd_count_o(mgr_rd_count_o),
    .mgr_rsp_i(mgr_rsp), .mgr_wr_err_i(wr_err), .mgr_rd_err_i(rd_err), .mgr_data_i(mgr_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    req_wdata = '0;
    req_count = '0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*32 +: 32] = v_addr[i];
      req_wdata[i*64 +: 64] = v_wdata[i];
      req_count[i*8 +: 8] = v_cnt[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model rule: first valid requester at or after the pointer, wrapping.
  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // Plays the manager for one granted command and checks every observable step.
  task automatic serve(input int eg, input logic drop, input logic [1:0] derr, input logic [63:0] drd,
                       input int dly, input logic stray, input logic [1:0] eerr, input logic [63:0] erd);
    int t;
    logic [1:0] mr;
    t = 0;
    while (req_ready_o == 4'b0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("ready", {60'b0, req_ready_o}, 64'd1 << eg);
    chk("grant_id", {62'b0, grant_id_o}, eg);
    chk("busy_accept", {63'b0, busy_o}, 1);
    if (drop) vld[eg] = 1'b0;
    mr = we[eg] ? 2'b01 : 2'b10;
    @(negedge clk);
    chk("mgr_req", {62'b0, mgr_req_o}, {62'b0, mr});
    chk("wr_addr", {32'b0, mgr_wr_addr_o}, we[eg] ? {32'b0, v_addr[eg]} : 64'd0);
    chk("rd_addr", {32'b0, mgr_rd_addr_o}, we[eg] ? 64'd0 : {32'b0, v_addr[eg]});
    chk("wr_count", {56'b0, mgr_wr_count_o}, we[eg] ? {56'b0, v_cnt[eg]} : 64'd0);
    chk("rd_count", {56'b0, mgr_rd_count_o}, we[eg] ? 64'd0 : {56'b0, v_cnt[eg]});
    chk("mgr_data", mgr_data_o, we[eg] ? v_wdata[eg] : 64'd0);
    for (int d = 0; d < dly; d++) begin
      mgr_rsp = stray ? ~mr : 2'b00;
      @(negedge clk);
      chk("mgr_req_hold", {62'b0, mgr_req_o}, {62'b0, mr});
      chk("done_early", {60'b0, done_o}, 0);
    end
    mgr_rsp = mr;
    wr_err = we[eg] ? derr : ~derr;
    rd_err = we[eg] ? ~derr : derr;
    mgr_rdata = drd;
    @(negedge clk);
    mgr_rsp = 2'b00;
    chk("done", {60'b0, done_o}, 64'd1 << eg);
    chk("err", {62'b0, err_o}, {62'b0, eerr});
    chk("rdata", rdata_o, erd);
    chk("mgr_req_clear", {62'b0, mgr_req_o}, 0);
    @(negedge clk);
    chk("done_pulse", {60'b0, done_o}, 0);
    chk("busy_idle", {63'b0, busy_o}, 0);
    mrd = erd;
  endtask

  typedef struct {
    int id; logic w; logic [31:0] addr; logic [63:0] wdata; logic [7:0] cnt;
    logic [1:0] derr; logic [63:0] drd; int dly; logic stray;
    logic [1:0] eerr; logic [63:0] erd;
  } vec_t;
  vec_t tv [5];

  initial begin
    int g, t;
    logic [1:0] de;
    logic [63:0] dr, er;
    tv[0] = '{1, 1'b1, 32'h5000, 64'hDEADBEEF0B501E7E, 8'd7, 2'b00, 64'h0BAD0BAD0BAD0BAD, 4, 1'b0, 2'b00, 64'h0};
    tv[1] = '{0, 1'b0, 32'h6000, 64'h0, 8'd4, 2'b00, 64'h1122334455667788, 2, 1'b0, 2'b00, 64'h1122334455667788};
    tv[2] = '{2, 1'b0, 32'h7000, 64'h0, 8'd1, 2'b10, 64'hA5A5A5A5A5A5A5A5, 3, 1'b1, 2'b10, 64'hA5A5A5A5A5A5A5A5};
    tv[3] = '{3, 1'b1, 32'h8000, 64'h0123456789ABCDEF, 8'd0, 2'b01, 64'h5555AAAA5555AAAA, 0, 1'b0, 2'b01, 64'hA5A5A5A5A5A5A5A5};
    tv[4] = '{1, 1'b0, 32'hFFFFFFF8, 64'h0, 8'd255, 2'b11, 64'hFFFFFFFFFFFFFFFF, 1, 1'b1, 2'b11, 64'hFFFFFFFFFFFFFFFF};
    rst = 1'b1;
    vld = '0;
    we = '0;
    mgr_rsp = '0;
    wr_err = '0;
    rd_err = '0;
    mgr_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      v_addr[i] = '0;
      v_wdata[i] = '0;
      v_cnt[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_ready", {60'b0, req_ready_o}, 0);
    chk("rst_done", {60'b0, done_o}, 0);
    chk("rst_busy", {63'b0, busy_o}, 0);
    chk("rst_mgr_req", {62'b0, mgr_req_o}, 0);
    chk("rst_err", {62'b0, err_o}, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_grant", {62'b0, grant_id_o}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Fairness: everyone valid the whole time.
    for (int i = 0; i < 4; i++) begin
      we[i] = 1'($urandom);
      v_addr[i] = 32'h1000 * (i + 1);
      v_wdata[i] = {$urandom, $urandom};
      v_cnt[i] = 8'(i + 3);
    end
    vld = 4'hF;
    for (int n = 0; n < 6; n++) begin
      dr = {$urandom, $urandom};
      er = we[n % 4] ? mrd : dr;
      serve(n % 4, 1'b0, 2'b00, dr, 2, 1'b0, 2'b00, er);
    end
    vld = '0;
    ptr = 2;

    // Reset in the middle of a request.
    we[2] = 1'b0;
    vld[2] = 1'b1;
    t = 0;
    while (req_ready_o == 4'b0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("mid_ready", {60'b0, req_ready_o}, 4);
    @(negedge clk);
    chk("mid_mgr_req", {62'b0, mgr_req_o}, 2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_mgr_req", {62'b0, mgr_req_o}, 0);
    chk("mid_rst_busy", {63'b0, busy_o}, 0);
    chk("mid_rst_done", {60'b0, done_o}, 0);
    chk("mid_rst_rdata", rdata_o, 0);
    @(negedge clk);
    rst = 1'b0;
    mrd = '0;
    vld = 4'hF;
    dr = {$urandom, $urandom};
    serve(0, 1'b0, 2'b01, dr, 1, 1'b0, 2'b01, we[0] ? mrd : dr);
    vld = '0;
    ptr = 1;

    // Directed vectors, one requester at a time.
    for (int n = 0; n < 5; n++) begin
      we[tv[n].id] = tv[n].w;
      v_addr[tv[n].id] = tv[n].addr;
      v_wdata[tv[n].id] = tv[n].wdata;
      v_cnt[tv[n].id] = tv[n].cnt;
      vld[tv[n].id] = 1'b1;
      if (n == 0) mrd = '0;
      serve(tv[n].id, 1'b1, tv[n].derr, tv[n].drd, tv[n].dly, tv[n].stray, tv[n].eerr,
            (n == 0) ? rdata_o : tv[n].erd);
      ptr = (tv[n].id + 1) % 4;
    end
    mrd = tv[4].erd;

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) if (!vld[i] && $urandom_range(1, 0) == 1) begin
        we[i] = 1'($urandom);
        v_addr[i] = $urandom;
        v_wdata[i] = {$urandom, $urandom};
        v_cnt[i] = 8'($urandom);
        vld[i] = 1'b1;
      end
      if (vld == 4'b0) vld[$urandom_range(3, 0)] = 1'b1;
      g = pick(vld, ptr);
      de = 2'($urandom);
      dr = {$urandom, $urandom};
      er = we[g] ? mrd : dr;
      serve(g, 1'b1, de, dr, $urandom_range(3, 0), 1'($urandom), de, er);
      ptr = (g + 1) % 4;
    end
    vld = '0;
    @(negedge clk);

`ifdef AXI4_MGR_SCHED_TIMEOUT_EN
    we[3] = 1'b0;
    vld[3] = 1'b1;
    t = 0;
    while (req_ready_o == 4'b0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("tmo_ready", {60'b0, req_ready_o}, 8);
    vld[3] = 1'b0;
    for (int c = 1; c < 16; c++) begin
      @(negedge clk);
      chk("tmo_early", {60'b0, done_o}, 0);
    end
    @(negedge clk);
    chk("tmo_done", {60'b0, done_o}, 8);
    chk("tmo_err", {62'b0, err_o}, 3);
    chk("tmo_rdata", rdata_o, 0);
    chk("tmo_busy", {63'b0, busy_o}, 1);
    chk("tmo_mgr_req", {62'b0, mgr_req_o}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("drain_done", {60'b0, done_o}, 0);
      chk("drain_busy", {63'b0, busy_o}, 1);
    end
    mgr_rsp = 2'b10;
    @(negedge clk);
    mgr_rsp = 2'b00;
    chk("drain_exit_busy", {63'b0, busy_o}, 0);
    chk("drain_no_done", {60'b0, done_o}, 0);
    ptr = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi4_mgr_sched.md
Name: axi4_mgr_sched

Overview:
- Round-robin scheduler that shares one axi4_mgr instance between NUM_REQ requesters.
- Accepts one read or write command at a time from a requester and drives the manager's req/address/data/count inputs.
- Waits for the manager response, then returns the error code and read data to the granted requester.
- Sits directly in front of axi4_mgr; each requester is typically a DMA or test client.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- AXI_ADDR_WIDTH, 32, address width
- AXI_DATA_WIDTH, 64, data width
- DATA_COUNT_WIDTH, 8, beat-count width; matches axi4_mgr
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  NUM_REQ  command valid, one bit per requester
- req_ready_o  out  NUM_REQ  command accepted (one-hot, single-cycle)
- req_we_i  in  NUM_REQ  1 = write, 0 = read
- req_addr_i  in  NUM_REQ*AXI_ADDR_WIDTH  packed addresses, requester i at slice i
- req_wdata_i  in  NUM_REQ*AXI_DATA_WIDTH  packed write data
- req_count_i  in  NUM_REQ*DATA_COUNT_WIDTH  packed beat counts
- done_o  out  NUM_REQ  one-hot, one-cycle completion pulse
- err_o  out  2  response code for the completed command
- rdata_o  out  AXI_DATA_WIDTH  read data for the completed command
- busy_o  out  1  command in flight
- grant_id_o  out  $clog2(NUM_REQ)  index of the current or last granted requester
- mgr_req_o  out  2  bit0 = write request, bit1 = read request
- mgr_wr_addr_o / mgr_rd_addr_o  out  AXI_ADDR_WIDTH  addresses to the manager
- mgr_data_o  out  AXI_DATA_WIDTH  write data to the manager
- mgr_wr_count_o / mgr_rd_count_o  out  DATA_COUNT_WIDTH  beat counts to the manager
- mgr_rsp_i  in  2  manager completion; bit0 = write, bit1 = read
- mgr_wr_err_i / mgr_rd_err_i  in  2  manager error codes
- mgr_data_i  in  AXI_DATA_WIDTH  manager read data

Behaviour:
- Reset: all outputs are 0; the round-robin pointer is 0; state is IDLE. Reset mid-transaction returns to IDLE immediately and drops mgr_req_o with no done pulse.
- All outputs are registered.
- State IDLE:
  - If any req_valid_i is high, grant the first valid index at or after the pointer, wrapping modulo NUM_REQ.
  - Assert req_ready_o[g] for that cycle only.
  - Latch we, addr, wdata and count into holding registers.
  - Set grant_id_o = g and busy_o = 1; go to REQ.
- State REQ:
  - Drive mgr_req_o = 2'b01 for write or 2'b10 for read. mgr_req_o is asserted one cycle after the accept cycle.
  - Drive the latched address and count on the matching mgr_wr_* or mgr_rd_* outputs; the unused side is driven to 0.
  - mgr_req_o is held, and the latched fields stay stable, until the matching mgr_rsp_i bit is sampled high.
  - A non-matching mgr_rsp_i bit is ignored.
- Response capture (in REQ, when the matching mgr_rsp_i bit is high):
  - Capture the matching err input into err_o; for reads, capture mgr_data_i into rdata_o.
  - Clear mgr_req_o in the same edge; go to DONE.
- State DONE:
  - done_o[g] = 1 for exactly one cycle; err_o and rdata_o are valid in this cycle and held until the next completion.
  - Pointer = (g+1) mod NUM_REQ; busy_o = 0; go to IDLE.
- Timing: minimum accept-to-accept spacing is 4 cycles (IDLE, REQ with immediate response, DONE, IDLE).
- Commands: a count of 0 is forwarded unchanged. req_valid_i may drop before the grant; nothing is latched for a requester not granted.
- Requester contract: a requester holds its fields stable while valid is high and ready is low.
- Fairness: with all requesters continuously valid, the grant sequence is 0,1,…,NUM_REQ-1,0,…
- No starvation: a requester waits at most NUM_REQ-1 other transactions.

Optional Feature:
- Macro: AXI4_MGR_SCHED_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ and is cleared on entry to REQ.
  - When it reaches TIMEOUT_CYCLES, pulse done_o[g] with err_o = 2'b11 and rdata_o = 0.
  - mgr_req_o drops. The block then enters DRAIN with busy_o = 1.
  - In DRAIN it waits for the outstanding mgr_rsp_i bit and discards that response, then returns to IDLE and advances the pointer.
  - A response arriving on the same cycle the counter hits the limit wins: normal completion, no timeout.
- Undefined: no counter and no DRAIN state; REQ waits indefinitely.

Test Plan:
- Single write: requester 1 with addr 0x5000, wdata 0xDEADBEEF0B501E7E, count 7.
  - Expect ready[1] pulse at T; mgr_req_o = 01 and mgr_wr_addr_o = 0x5000 at T+1.
  - With mgr_rsp_i = 01 and wr_err 00 at T+5: done_o = 0010, err_o = 00 at T+6.
- Single read: requester 0 with addr 0x6000 and mgr_data_i = 0x1122334455667788 at response.
  - Expect rdata_o = 0x1122334455667788 and done_o[0] pulse; mgr_req_o = 10 throughout REQ.
- Fairness: all four requesters continuously valid, manager responding after 2 cycles.
  - Expect grant order 0,1,2,3,0,1 and no done pulse to a non-granted index.
- Error pass-through and stray response:
  - Read with mgr_rd_err_i = 10 yields err_o = 10.
  - A mgr_rsp_i = 01 during a read is ignored and mgr_req_o stays 10.
- Reset mid-flight: assert rst_i during REQ.
  - Expect mgr_req_o, busy_o and done_o = 0 asynchronously; after release, the next grant goes to index 0.
- Timeout (macro defined, TIMEOUT_CYCLES = 16, no response):
  - Expect done_o pulse with err_o = 11 after 16 REQ cycles and busy_o held.
  - A late mgr_rsp_i then returns the block to IDLE with no second done pulse.
